// File: rtl/regfile_670_ctl.sv
// ============================================================================
// regfile_670_ctl : timing controller for a 74x670 4x4 register file
//                   (independent write/read sequencers with conflict guard)
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_670_ctl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned READ_CYC  = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       wr_req,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [1:0] rd_addr,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [3:0] rd_data,
  output logic [3:0] d,
  output logic [1:0] wa,
  output logic       nwe,
  output logic [1:0] ra,
  output logic       nre,
  input  logic [3:0] q
);

  // Counters load N-1 on state entry and leave the state when they reach zero.
  localparam logic [3:0] c_setup_ld = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_pulse_ld = 4'(PULSE_CYC - 1);
  localparam logic [3:0] c_hold_ld  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] c_read_ld  = 4'(READ_CYC - 1);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wstate_t;
  typedef enum logic       {R_IDLE, R_WAIT}                   rstate_t;

  wstate_t    ws_q, ws_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       nwe_q, nwe_d;
  logic       wack_q, wack_d;
  logic [3:0] d_q, d_d;
  logic [1:0] wa_q, wa_d;

  rstate_t    rs_q, rs_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       nre_q, nre_d;
  logic [1:0] ra_q, ra_d;
  logic [3:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;

  logic       w_wr_ready;
  logic       w_conflict;

  assign w_wr_ready = (ws_q == W_IDLE);
  // A read must not overlap a pending or in-flight write to the same cell.
  assign w_conflict = ((ws_q != W_IDLE) && (rd_addr == wa_q)) ||
                      (wr_req && w_wr_ready && (rd_addr == wr_addr));

  always_comb begin
    ws_d   = ws_q;
    wcnt_d = wcnt_q;
    nwe_d  = nwe_q;
    wack_d = 1'b0;
    d_d    = d_q;
    wa_d   = wa_q;
    case (ws_q)
      W_IDLE: begin
        if (wr_req) begin
          ws_d   = W_SETUP;
          wcnt_d = c_setup_ld;
          d_d    = wr_data;
          wa_d   = wr_addr;
        end
      end
      W_SETUP: begin
        if (wcnt_q == 4'd0) begin
          ws_d   = W_PULSE;
          wcnt_d = c_pulse_ld;
          nwe_d  = 1'b0;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      W_PULSE: begin
        if (wcnt_q == 4'd0) begin
          ws_d   = W_HOLD;
          wcnt_d = c_hold_ld;
          nwe_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      W_HOLD: begin
        if (wcnt_q == 4'd0) begin
          ws_d   = W_IDLE;
          wack_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        ws_d  = W_IDLE;
        nwe_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    rs_d     = rs_q;
    rcnt_d   = rcnt_q;
    nre_d    = nre_q;
    ra_d     = ra_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (rs_q)
      R_IDLE: begin
        if (rd_req && !w_conflict) begin
          rs_d   = R_WAIT;
          rcnt_d = c_read_ld;
          ra_d   = rd_addr;
          nre_d  = 1'b0;
        end
      end
      R_WAIT: begin
        if (rcnt_q == 4'd0) begin
          rs_d     = R_IDLE;
          rdata_d  = q;
          rvalid_d = 1'b1;
          nre_d    = 1'b1;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      default: begin
        rs_d  = R_IDLE;
        nre_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ws_q     <= W_IDLE;
      wcnt_q   <= 4'd0;
      nwe_q    <= 1'b1;
      wack_q   <= 1'b0;
      d_q      <= 4'd0;
      wa_q     <= 2'd0;
      rs_q     <= R_IDLE;
      rcnt_q   <= 4'd0;
      nre_q    <= 1'b1;
      ra_q     <= 2'd0;
      rdata_q  <= 4'd0;
      rvalid_q <= 1'b0;
    end else begin
      ws_q     <= ws_d;
      wcnt_q   <= wcnt_d;
      nwe_q    <= nwe_d;
      wack_q   <= wack_d;
      d_q      <= d_d;
      wa_q     <= wa_d;
      rs_q     <= rs_d;
      rcnt_q   <= rcnt_d;
      nre_q    <= nre_d;
      ra_q     <= ra_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign wr_ready = w_wr_ready;
  assign wr_ack   = wack_q;
  assign rd_ready = (rs_q == R_IDLE) && !w_conflict;
  assign rd_valid = rvalid_q;
  assign rd_data  = rdata_q;
  assign d        = d_q;
  assign wa       = wa_q;
  assign nwe      = nwe_q;
  assign ra       = ra_q;
  assign nre      = nre_q;

endmodule

`default_nettype wire

// File: doc/regfile_670_ctl.md
REGFILE_670_CTL -- requirements
Module: regfile_670_ctl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles d/wa are stable before nwe falls; legal range 1..15.
REQ-002 SHALL have parameter PULSE_CYC, default 2: cycles nwe is held low; legal range 1..15.
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles d/wa are held after nwe rises; legal range 1..15.
REQ-004 SHALL have parameter READ_CYC, default 2: cycles nre is held low before q is sampled; legal range 1..15.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, listed first: clk (in, 1, rising-edge clock) and nreset (in, 1, async active-low reset).
REQ-006 SHALL have ports: wr_req (in, 1, write request), wr_addr (in, 2, write address), wr_data (in, 4, write data), wr_ready (out, 1, write port idle), wr_ack (out, 1, one-cycle write-complete pulse).
REQ-007 SHALL have ports: rd_req (in, 1, read request), rd_addr (in, 2, read address), rd_ready (out, 1, read accept allowed), rd_valid (out, 1, one-cycle read-data strobe), rd_data (out, 4, captured read data).
REQ-008 SHALL have ports to the 74x670: d (out, 4), wa (out, 2), nwe (out, 1, active low), ra (out, 2), nre (out, 1, active low), q (in, 4, tri-state read bus).

Function
REQ-009 SHALL implement independent write and read state machines; the write FSM has states W_IDLE, W_SETUP, W_PULSE, W_HOLD; the read FSM has states R_IDLE, R_WAIT.
REQ-010 SHALL accept a write on a rising edge where wr_req=1 and wr_ready=1, latching wr_addr into wa and wr_data into d, and entering W_SETUP.
REQ-011 SHALL keep wr_ready=1 only in W_IDLE; wr_req is ignored otherwise, and d/wa SHALL NOT change outside W_IDLE.
REQ-012 SHALL dwell exactly SETUP_CYC cycles in W_SETUP (nwe=1), then PULSE_CYC cycles in W_PULSE (nwe=0), then HOLD_CYC cycles in W_HOLD (nwe=1), then return to W_IDLE.
REQ-013 SHALL drive nwe from a register only, glitch-free; nwe=0 only in W_PULSE.
REQ-014 SHALL assert wr_ack for exactly the first cycle back in W_IDLE, i.e. SETUP_CYC+PULSE_CYC+HOLD_CYC edges after the accept edge (4 at defaults); a new write may be accepted on the edge ending that cycle.
REQ-015 SHALL accept a read on a rising edge where rd_req=1 and rd_ready=1, latching rd_addr into ra, driving nre=0 and entering R_WAIT.
REQ-016 SHALL stay in R_WAIT for READ_CYC cycles; on the edge ending the last cycle it SHALL load q into rd_data, set rd_valid=1 for one cycle, set nre=1 and return to R_IDLE.
REQ-017 SHALL hold rd_data stable between rd_valid strobes.
REQ-018 SHALL compute rd_ready = (R_IDLE) AND NOT conflict, where conflict = (write FSM not in W_IDLE AND rd_addr==wa) OR (wr_req AND wr_ready AND rd_addr==wr_addr).
REQ-019 SHALL give a write priority over a simultaneous same-address read; the read is accepted only after the write returns to W_IDLE (the wr_ack cycle or later).
REQ-020 SHALL allow reads of a different address to proceed concurrently with a write in any write state.
REQ-021 SHALL allow back-to-back reads: a new read may be accepted on the edge ending the rd_valid cycle.
REQ-022 SHALL use 4-bit dwell counters that reload on each state entry; no counter may wrap.

Reset
REQ-023 SHALL, while nreset=0 and regardless of clk, force W_IDLE, R_IDLE, nwe=1, nre=1, d=0, wa=0, ra=0, rd_data=0, rd_valid=0, wr_ack=0, wr_ready=1.
REQ-024 SHALL abort any in-progress write or read on reset assertion, with nwe/nre rising immediately; an aborted operation SHALL produce no wr_ack or rd_valid.
REQ-025 SHALL accept requests on the first rising edge after nreset deasserts.

Verification
REQ-026 Write wa=2, d=4'hA at defaults -> nwe low for exactly 2 cycles starting 1 cycle after accept; d/wa stable throughout; wr_ack exactly 4 cycles after accept; model cell 2 = 4'hA.
REQ-027 After writing 1,2,4,8 to addresses 0..3, read addresses 3,2,1,0 back-to-back -> rd_valid every 3 cycles with rd_data 8,4,2,1; nre=1 and q=Z between reads.
REQ-028 Same-cycle wr_req (addr 1, data 5) and rd_req (addr 1) -> rd_ready=0 until wr_ack; read returns 5, never the stale value.
REQ-029 Write addr 0 while reading addr 3 -> both proceed concurrently; read data correct and write timing unchanged.
REQ-030 Assert nreset during W_PULSE -> nwe=1 in the same timestep; no wr_ack; all outputs at reset values.
REQ-031 Parameters SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, READ_CYC=1 -> nwe low 1 cycle starting 3 cycles after accept, wr_ack 6 cycles after accept, rd_valid 1 cycle after read accept.
